layer_compositor: RTL and testbench

// - Parametrised, pipelined pixel compositor that turns DrawX/DrawY into registered RGB.
// - Layers, highest priority first: N circular sprites (Pac-Man plus ghosts), pellets, power pellets, maze ROM bitmap, black.
// - Adds frame-synchronous animation modes: power-pellet blink, frightened ghosts and level-clear maze flash.
// - Sits between the VGA controller and the DAC pins; feeds the maze ROM address and realigns layer flags to the ROM read latency.

---
 rtl/compositor_pkg.sv | 27 ++
 rtl/sprite_hit.sv | 27 ++
 rtl/layer_compositor.sv | 138 +++++++++++++
 tb/tb_layer_compositor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/compositor_pkg.sv
// Shared types and colour constants for the layer compositor.
package compositor_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL      = 2'd0,
    MODE_FRIGHT      = 2'd1,
    MODE_LEVEL_CLEAR = 2'd2
  } comp_mode_t;

  localparam logic [23:0] C_PELLET = 24'hFFB7AE;
  localparam logic [23:0] C_MAZE   = 24'h2121FF;
  localparam logic [23:0] C_FRIGHT = 24'h2121FF;
  localparam logic [23:0] C_WHITE  = 24'hFFFFFF;
  localparam logic [23:0] C_BLACK  = 24'h000000;

  // Ghost colour: frightened blue, flashing white near the end of fright.
  function automatic logic [23:0] ghost_colour(input comp_mode_t  mode,
                                               input logic        ending,
                                               input logic        blink,
                                               input logic [23:0] normal);
    if (mode == MODE_FRIGHT) begin
      return (ending && blink) ? C_WHITE : C_FRIGHT;
    end
    return normal;
  endfunction

endpackage

// File: rtl/sprite_hit.sv
// Circle hit test for one sprite: (x-cx)^2 + (y-cy)^2 <= r^2, exact in 23 bits.
module sprite_hit (
  input  logic [9:0] draw_x_i,
  input  logic [9:0] draw_y_i,
  input  logic [9:0] spr_x_i,
  input  logic [9:0] spr_y_i,
  input  logic [9:0] spr_r_i,
  input  logic       en_i,
  output logic       hit_o
);

  logic signed [10:0] dx, dy;
  logic [9:0]         adx, ady;
  logic [22:0]        dist_sq, rad_sq;

  // Squares are taken on magnitudes so the sum stays unsigned and untruncated.
  always_comb begin
    dx      = $signed({1'b0, draw_x_i}) - $signed({1'b0, spr_x_i});
    dy      = $signed({1'b0, draw_y_i}) - $signed({1'b0, spr_y_i});
    adx     = dx[10] ? 10'(-dx) : dx[9:0];
    ady     = dy[10] ? 10'(-dy) : dy[9:0];
    dist_sq = 23'(adx) * 23'(adx) + 23'(ady) * 23'(ady);
    rad_sq  = 23'(spr_r_i) * 23'(spr_r_i);
    hit_o   = en_i && (dist_sq <= rad_sq);
  end

endmodule

// File: rtl/layer_compositor.sv
// Pipelined pixel compositor: sprites > pellet > power pellet > maze > black.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int unsigned NUM_SPRITES  = 5,
  parameter int unsigned ROM_LATENCY  = 1,
  parameter int unsigned H_RES        = 640,
  parameter int unsigned MAZE_X_MIN   = 16,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      frame_start_i,
  input  logic [9:0]                draw_x_i,
  input  logic [9:0]                draw_y_i,
  input  logic                      blank_i,
  input  logic [10*NUM_SPRITES-1:0] sprite_x_i,
  input  logic [10*NUM_SPRITES-1:0] sprite_y_i,
  input  logic [10*NUM_SPRITES-1:0] sprite_r_i,
  input  logic [NUM_SPRITES-1:0]    sprite_en_i,
  input  logic [24*NUM_SPRITES-1:0] sprite_rgb_i,
  input  logic                      pellet_on_i,
  input  logic                      power_on_i,
  input  logic [1:0]                mode_req_i,
  input  logic                      fright_ending_i,
  output logic [18:0]               maze_rom_addr_o,
  input  logic                      maze_rom_data_i,
  output logic [7:0]                red_o,
  output logic [7:0]                green_o,
  output logic [7:0]                blue_o
);

  // Flag vector layout: {hits, pellet, power, blank, x_past_maze_min}
  localparam int unsigned FlagW = NUM_SPRITES + 4;
  localparam int unsigned CntW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [NUM_SPRITES-1:0] hit;
  logic [FlagW-1:0]       flags_in, flags_dly;
  logic [FlagW-1:0]       dly_q [ROM_LATENCY];

  comp_mode_t             mode_q, mode_d;
  logic [CntW-1:0]        frame_cnt_q, frame_cnt_d;
  logic                   blink_q, blink_d;
  logic [23:0]            rgb_q, rgb_d;

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
    sprite_hit u_sprite_hit (
      .draw_x_i (draw_x_i),
      .draw_y_i (draw_y_i),
      .spr_x_i  (sprite_x_i[10*i +: 10]),
      .spr_y_i  (sprite_y_i[10*i +: 10]),
      .spr_r_i  (sprite_r_i[10*i +: 10]),
      .en_i     (sprite_en_i[i]),
      .hit_o    (hit[i])
    );
  end

  // ROM address and stage-0 flag bundle.
  always_comb begin
    maze_rom_addr_o = 19'(draw_y_i) * 19'(H_RES) + 19'(draw_x_i);
    flags_in        = {hit, pellet_on_i, power_on_i, blank_i,
                       (draw_x_i > 10'(MAZE_X_MIN))};
  end

  // Delay flags by the ROM latency; a cleared blank bit keeps reset refill black.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(ROM_LATENCY); i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= flags_in;
      for (int i = 1; i < int'(ROM_LATENCY); i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign flags_dly = dly_q[ROM_LATENCY-1];

  // Frame-synchronous mode latch and blink counter.
  always_comb begin
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (frame_start_i) begin
      case (mode_req_i)
        2'd1:    mode_d = MODE_FRIGHT;
        2'd2:    mode_d = MODE_LEVEL_CLEAR;
        default: mode_d = MODE_NORMAL;
      endcase
      if (frame_cnt_q == CntW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Frame state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q      <= MODE_NORMAL;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  // Layer priority mux; lower layers first so higher ones overwrite.
  always_comb begin
    rgb_d = C_BLACK;
    if (maze_rom_data_i && flags_dly[0]) begin
      rgb_d = (mode_q == MODE_LEVEL_CLEAR && blink_q) ? C_WHITE : C_MAZE;
    end
    if (flags_dly[2] && !blink_q) rgb_d = C_PELLET;
    if (flags_dly[3])             rgb_d = C_PELLET;
    for (int i = int'(NUM_SPRITES) - 1; i >= 0; i--) begin
      if (flags_dly[4 + i]) begin
        if (i == 0) rgb_d = sprite_rgb_i[23:0];
        else        rgb_d = ghost_colour(mode_q, fright_ending_i, blink_q,
                                         sprite_rgb_i[24*i +: 24]);
      end
    end
    if (!flags_dly[1]) rgb_d = C_BLACK;
  end

  // Registered colour output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rgb_q <= C_BLACK;
    else       rgb_q <= rgb_d;
  end

  assign red_o   = rgb_q[23:16];
  assign green_o = rgb_q[15:8];
  assign blue_o  = rgb_q[7:0];

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor (ROM_LATENCY=1, BLINK_FRAMES=4).
module tb_layer_compositor;

  localparam int NS = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           frame_start;
  logic [9:0]     draw_x, draw_y;
  logic           blank;
  logic [10*NS-1:0] spr_x, spr_y, spr_r;
  logic [NS-1:0]  spr_en;
  logic [24*NS-1:0] spr_rgb;
  logic           pellet, power;
  logic [1:0]     mode_req;
  logic           fright_ending;
  logic [18:0]    rom_addr;
  logic           rom_data;
  logic [7:0]     red, green, blue;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  layer_compositor #(
    .NUM_SPRITES  (NS),
    .ROM_LATENCY  (1),
    .H_RES        (640),
    .MAZE_X_MIN   (16),
    .BLINK_FRAMES (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .frame_start_i   (frame_start),
    .draw_x_i        (draw_x),
    .draw_y_i        (draw_y),
    .blank_i         (blank),
    .sprite_x_i      (spr_x),
    .sprite_y_i      (spr_y),
    .sprite_r_i      (spr_r),
    .sprite_en_i     (spr_en),
    .sprite_rgb_i    (spr_rgb),
    .pellet_on_i     (pellet),
    .power_on_i      (power),
    .mode_req_i      (mode_req),
    .fright_ending_i (fright_ending),
    .maze_rom_addr_o (rom_addr),
    .maze_rom_data_i (rom_data),
    .red_o           (red),
    .green_o         (green),
    .blue_o          (blue)
  );

  // Maze ROM model: row 100 is solid wall, one-cycle read latency.
  always @(posedge clk) rom_data <= (rom_addr >= 19'd64000) && (rom_addr < 19'd64640);

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic        pellet;
    logic        power;
    logic [23:0] exp;
    string       name;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h", name, got, exp);
    end
  endtask

  task automatic set_pix(input logic [9:0] x, input logic [9:0] y, input logic b,
                         input logic pel, input logic pow);
    draw_x = x; draw_y = y; blank = b; pellet = pel; power = pow;
  endtask

  task automatic pix(input string name, input logic [9:0] x, input logic [9:0] y,
                     input logic pel, input logic pow, input logic [23:0] exp);
    set_pix(x, y, 1'b1, pel, pow);
    step();
    step();
    check(name, {red, green, blue}, exp);
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Sprites: 0 Pac-Man, 1 same centre, 2 ghost on the maze row, 3 disabled, 4 radius 0.
    spr_x   = {10'd500, 10'd200, 10'd100, 10'd320, 10'd320};
    spr_y   = {10'd300, 10'd100, 10'd100, 10'd240, 10'd240};
    spr_r   = {10'd0,   10'd5,   10'd3,   10'd6,   10'd6};
    spr_en  = 5'b10111;
    spr_rgb = {24'hFFB852, 24'h00FFFF, 24'hFFB8FF, 24'hFF0000, 24'hFFFF00};
    frame_start = 1'b0; mode_req = 2'd0; fright_ending = 1'b0;
    set_pix(10'd326, 10'd240, 1'b1, 1'b0, 1'b0);

    vecs[0]  = '{10'd326, 10'd240, 1'b1, 1'b0, 1'b0, 24'hFFFF00, "spr0_edge_x"};
    vecs[1]  = '{10'd327, 10'd240, 1'b1, 1'b0, 1'b0, 24'h000000, "spr0_outside_x"};
    vecs[2]  = '{10'd320, 10'd246, 1'b1, 1'b0, 1'b0, 24'hFFFF00, "spr0_edge_y"};
    vecs[3]  = '{10'd325, 10'd244, 1'b1, 1'b0, 1'b0, 24'h000000, "spr0_diag_out"};
    vecs[4]  = '{10'd324, 10'd244, 1'b1, 1'b0, 1'b0, 24'hFFFF00, "spr0_diag_in"};
    vecs[5]  = '{10'd314, 10'd240, 1'b1, 1'b0, 1'b0, 24'hFFFF00, "spr0_neg_dx"};
    vecs[6]  = '{10'd100, 10'd100, 1'b1, 1'b0, 1'b0, 24'hFFB8FF, "ghost_over_maze"};
    vecs[7]  = '{10'd103, 10'd100, 1'b1, 1'b0, 1'b0, 24'hFFB8FF, "ghost_edge"};
    vecs[8]  = '{10'd104, 10'd100, 1'b1, 1'b0, 1'b0, 24'h2121FF, "maze_beside_ghost"};
    vecs[9]  = '{10'd16,  10'd100, 1'b1, 1'b0, 1'b0, 24'h000000, "maze_x16_off"};
    vecs[10] = '{10'd17,  10'd100, 1'b1, 1'b0, 1'b0, 24'h2121FF, "maze_x17_on"};
    vecs[11] = '{10'd17,  10'd100, 1'b0, 1'b0, 1'b0, 24'h000000, "maze_blanked"};
    vecs[12] = '{10'd326, 10'd240, 1'b1, 1'b1, 1'b0, 24'hFFFF00, "sprite_hides_pellet"};
    vecs[13] = '{10'd50,  10'd50,  1'b1, 1'b1, 1'b0, 24'hFFB7AE, "pellet"};
    vecs[14] = '{10'd50,  10'd50,  1'b1, 1'b0, 1'b1, 24'hFFB7AE, "power_pellet"};
    vecs[15] = '{10'd50,  10'd100, 1'b1, 1'b1, 1'b0, 24'hFFB7AE, "pellet_over_maze"};
    vecs[16] = '{10'd200, 10'd100, 1'b1, 1'b0, 1'b0, 24'h2121FF, "disabled_sprite"};
    vecs[17] = '{10'd500, 10'd300, 1'b1, 1'b0, 1'b0, 24'hFFB852, "radius0_centre"};
    vecs[18] = '{10'd501, 10'd300, 1'b1, 1'b0, 1'b0, 24'h000000, "radius0_off"};

    rst = 1'b1;
    step();
    check("reset_rgb", {red, green, blue}, 24'h000000);
    step();
    check("reset_rgb_held", {red, green, blue}, 24'h000000);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      set_pix(vecs[i].x, vecs[i].y, vecs[i].blank, vecs[i].pellet, vecs[i].power);
      step();
      step();
      check(vecs[i].name, {red, green, blue}, vecs[i].exp);
    end

    // ROM address
    set_pix(10'd17, 10'd100, 1'b1, 1'b0, 1'b0);
    #1;
    check("rom_addr_17_100", 24'(rom_addr), 24'd64017);
    set_pix(10'd639, 10'd479, 1'b1, 1'b0, 1'b0);
    #1;
    check("rom_addr_639_479", 24'(rom_addr), 24'd307199);

    // Latency: two cycles from pixel to colour
    pix("lat_pre", 10'd0, 10'd0, 1'b0, 1'b0, 24'h000000);
    set_pix(10'd326, 10'd240, 1'b1, 1'b0, 1'b0);
    step();
    check("lat_edge1", {red, green, blue}, 24'h000000);
    set_pix(10'd17, 10'd100, 1'b1, 1'b0, 1'b0);
    step();
    check("lat_edge2", {red, green, blue}, 24'hFFFF00);
    step();
    check("lat_edge3", {red, green, blue}, 24'h2121FF);

    // Reset mid-stream: black until the pipeline refills
    pix("rst_pre", 10'd326, 10'd240, 1'b0, 1'b0, 24'hFFFF00);
    rst = 1'b1;
    #1;
    check("rst_async", {red, green, blue}, 24'h000000);
    step();
    rst = 1'b0;
    step();
    check("rst_refill1", {red, green, blue}, 24'h000000);
    step();
    check("rst_refill2", {red, green, blue}, 24'hFFFF00);

    // Power pellet blink: visible frames 0-3, hidden 4-7, visible at 8
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) frame_pulse();
      pix($sformatf("blink_frame%0d", k), 10'd50, 10'd50, 1'b0, 1'b1,
          (k < 4 || k >= 8) ? 24'hFFB7AE : 24'h000000);
    end

    // frame_start together with reset: counter must not advance
    rst = 1'b1;
    frame_start = 1'b1;
    step();
    rst = 1'b0;
    frame_start = 1'b0;
    frame_pulse(); frame_pulse(); frame_pulse();
    pix("rst_beats_frame_3", 10'd50, 10'd50, 1'b0, 1'b1, 24'hFFB7AE);
    frame_pulse();
    pix("rst_beats_frame_4", 10'd50, 10'd50, 1'b0, 1'b1, 24'h000000);

    // Frightened mode
    do_reset();
    mode_req = 2'd1;
    pix("fright_midframe", 10'd100, 10'd100, 1'b0, 1'b0, 24'hFFB8FF);
    frame_pulse();
    pix("fright_ghost", 10'd100, 10'd100, 1'b0, 1'b0, 24'h2121FF);
    pix("fright_pacman", 10'd326, 10'd240, 1'b0, 1'b0, 24'hFFFF00);
    pix("fright_overlap", 10'd320, 10'd240, 1'b0, 1'b0, 24'hFFFF00);
    fright_ending = 1'b1;
    pix("fright_end_blue", 10'd100, 10'd100, 1'b0, 1'b0, 24'h2121FF);
    frame_pulse(); frame_pulse(); frame_pulse();
    pix("fright_end_white", 10'd100, 10'd100, 1'b0, 1'b0, 24'hFFFFFF);
    for (int k = 0; k < 4; k++) frame_pulse();
    pix("fright_end_blue2", 10'd100, 10'd100, 1'b0, 1'b0, 24'h2121FF);
    fright_ending = 1'b0;

    // Level clear flash, then reserved mode
    do_reset();
    mode_req = 2'd2;
    frame_pulse();
    pix("lvl_maze_blue", 10'd17, 10'd100, 1'b0, 1'b0, 24'h2121FF);
    frame_pulse(); frame_pulse(); frame_pulse();
    pix("lvl_maze_white", 10'd17, 10'd100, 1'b0, 1'b0, 24'hFFFFFF);
    pix("lvl_ghost", 10'd100, 10'd100, 1'b0, 1'b0, 24'hFFB8FF);
    pix("lvl_pellet", 10'd50, 10'd50, 1'b1, 1'b0, 24'hFFB7AE);
    mode_req = 2'd3;
    frame_pulse();
    pix("mode3_maze", 10'd17, 10'd100, 1'b0, 1'b0, 24'h2121FF);
    pix("mode3_ghost", 10'd100, 10'd100, 1'b0, 1'b0, 24'hFFB8FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
